// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, steps it on cache hits and buffers hits for decode.
// Latency: a hit reaches o_inst one cycle later if the queue is empty; o_pc_next is same-cycle.
// Backpressure: a full queue with no pop refuses the hit and holds the PC, so the cache re-presents it.
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 26,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FQ_DEPTH   = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] o_pc_current,
    output logic [ADDR_WIDTH-1:0] o_pc_next,
    input  logic                  i_cache_valid,
    input  logic [DATA_WIDTH-1:0] i_cache_data,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_inst_valid,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_inst_pc,
    input  logic                  i_dec_ready,
    output logic [31:0]           o_miss_cycles
);
    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0]      DEPTH_CNT  = CNT_W'(FQ_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } fq_entry_t;

    logic [ADDR_WIDTH-1:0] pc_current_q, pc_next_d;
    fq_entry_t             fq_mem_q [FQ_DEPTH];
    fq_entry_t             fq_mem_d [FQ_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [31:0]           miss_cycles_q, miss_cycles_d;
    logic                  pop, accept;

    assign pop    = (count_q != '0) & i_dec_ready;
    assign accept = i_cache_valid & ~i_redirect_valid & ((count_q != DEPTH_CNT) | pop);

    always_comb begin
        pc_next_d = pc_current_q;
        if (rst) begin
            pc_next_d = RESET_PC;
        end else if (i_redirect_valid) begin
            pc_next_d = i_redirect_pc & ALIGN_MASK;
        end else if (accept) begin
            pc_next_d = pc_current_q + ADDR_WIDTH'(4);
        end
    end

    always_comb begin
        fq_mem_d = fq_mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (accept) begin
            fq_mem_d[wr_ptr_q] = '{pc: pc_current_q, inst: i_cache_data};
        end
        // A redirect flushes everything; a coincident pop needs no bookkeeping.
        if (i_redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({accept, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        miss_cycles_d = miss_cycles_q;
        if (!i_cache_valid && miss_cycles_q != 32'hFFFF_FFFF) begin
            miss_cycles_d = miss_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_current_q  <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            miss_cycles_q <= '0;
        end else begin
            pc_current_q  <= pc_next_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            miss_cycles_q <= miss_cycles_d;
        end
    end

    // Entry storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        fq_mem_q <= fq_mem_d;
    end

    assign o_pc_current  = pc_current_q;
    assign o_pc_next     = pc_next_d;
    assign o_inst_valid  = (count_q != '0);
    assign o_inst        = fq_mem_q[rd_ptr_q].inst;
    assign o_inst_pc     = fq_mem_q[rd_ptr_q].pc;
    assign o_miss_cycles = miss_cycles_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC stepping, miss hold, full-queue backpressure, redirect flush, wrap and reset.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] o_pc_current, o_pc_next;
    logic        i_cache_valid;
    logic [31:0] i_cache_data;
    logic        i_redirect_valid;
    logic [25:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [25:0] o_inst_pc;
    logic        i_dec_ready;
    logic [31:0] o_miss_cycles;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Cache model: the instruction word encodes its own address.
    assign i_cache_data = 32'hC000_0000 | {6'd0, o_pc_current};

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .o_pc_current     (o_pc_current),
        .o_pc_next        (o_pc_next),
        .i_cache_valid    (i_cache_valid),
        .i_cache_data     (i_cache_data),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_inst_valid     (o_inst_valid),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .i_dec_ready      (i_dec_ready),
        .o_miss_cycles    (o_miss_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; i_cache_valid = 1'b0; i_redirect_valid = 1'b0;
        i_redirect_pc = '0; i_dec_ready = 1'b1;
        #1;
        check("rst_pc_next", 64'(o_pc_next), 64'h0);
        tick();
        check("rst_pc_current", 64'(o_pc_current), 64'h0);
        check("rst_inst_valid", 64'(o_inst_valid), 64'h0);
        check("rst_miss", 64'(o_miss_cycles), 64'h0);

        // Continuous hits with decode ready: PC steps by 4, head lags by one
        rst = 1'b0; i_cache_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_pc", 64'(o_pc_current), 64'(4 * (k + 1)));
            check("seq_vld", 64'(o_inst_valid), 64'h1);
            check("seq_inst_pc", 64'(o_inst_pc), 64'(4 * k));
            check("seq_inst", 64'(o_inst), 64'(32'hC000_0000 | (4 * k)));
        end

        // Redirect to 0x40 with a coincident hit: flush and discard
        i_redirect_valid = 1'b1; i_redirect_pc = 26'h40;
        tick();
        check("redir40_pc", 64'(o_pc_current), 64'h40);
        check("redir40_vld", 64'(o_inst_valid), 64'h0);

        // Ten miss cycles at 0x40
        i_redirect_valid = 1'b0; i_cache_valid = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("miss_pc", 64'(o_pc_current), 64'h40);
        check("miss_pc_next", 64'(o_pc_next), 64'h40);
        check("miss_vld", 64'(o_inst_valid), 64'h0);
        check("miss_cnt", 64'(o_miss_cycles), 64'd10);
        i_cache_valid = 1'b1;
        #1;
        check("hit_pc_next", 64'(o_pc_next), 64'h44);
        tick();
        check("hit40_vld", 64'(o_inst_valid), 64'h1);
        check("hit40_inst_pc", 64'(o_inst_pc), 64'h40);
        check("hit40_inst", 64'(o_inst), 64'hC000_0040);
        check("hit40_pc", 64'(o_pc_current), 64'h44);

        // Decode stalled: queue fills with 0 and 4, PC holds at 8
        i_redirect_valid = 1'b1; i_redirect_pc = 26'h0; i_dec_ready = 1'b0;
        tick();
        i_redirect_valid = 1'b0;
        tick(); tick(); tick();
        check("full_pc", 64'(o_pc_current), 64'h8);
        check("full_pc_next", 64'(o_pc_next), 64'h8);
        check("full_head", 64'(o_inst_pc), 64'h0);
        i_dec_ready = 1'b1;
        #1;
        check("resume_pc_next", 64'(o_pc_next), 64'hC);
        tick();
        check("pop2_head", 64'(o_inst_pc), 64'h4);
        check("pop2_pc", 64'(o_pc_current), 64'hC);
        tick();
        check("pop3_head", 64'(o_inst_pc), 64'h8);
        check("pop3_miss", 64'(o_miss_cycles), 64'd10);

        // Queue holds 2; redirect to unaligned 0x123 with a same-cycle hit
        i_dec_ready = 1'b0;
        i_redirect_valid = 1'b1; i_redirect_pc = 26'h123;
        #1;
        check("r123_pc_next", 64'(o_pc_next), 64'h120);
        tick();
        check("r123_pc", 64'(o_pc_current), 64'h120);
        check("r123_vld", 64'(o_inst_valid), 64'h0);
        i_redirect_valid = 1'b0; i_cache_valid = 1'b0;
        tick();
        check("r123_discard", 64'(o_inst_valid), 64'h0);
        check("r123_miss", 64'(o_miss_cycles), 64'd11);
        i_cache_valid = 1'b1; i_dec_ready = 1'b1;
        tick();
        check("r123_head_pc", 64'(o_inst_pc), 64'h120);
        check("r123_head", 64'(o_inst), 64'hC000_0120);

        // Top-of-space wrap
        i_redirect_valid = 1'b1; i_redirect_pc = 26'h3FF_FFFC;
        tick();
        i_redirect_valid = 1'b0;
        #1;
        check("wrap_pc_next", 64'(o_pc_next), 64'h0);
        tick();
        check("wrap_pc", 64'(o_pc_current), 64'h0);
        check("wrap_head", 64'(o_inst_pc), 64'h3FF_FFFC);

        // Fill the queue, then reset mid-operation
        i_dec_ready = 1'b0;
        tick(); tick();
        check("prerst_pc", 64'(o_pc_current), 64'h4);
        rst = 1'b1;
        #1;
        check("rst2_pc_next", 64'(o_pc_next), 64'h0);
        tick();
        check("rst2_pc", 64'(o_pc_current), 64'h0);
        check("rst2_vld", 64'(o_inst_valid), 64'h0);
        check("rst2_miss", 64'(o_miss_cycles), 64'h0);
        rst = 1'b0; i_cache_valid = 1'b0;
        tick();
        check("post_rst_vld", 64'(o_inst_valid), 64'h0);
        check("post_rst_miss", 64'(o_miss_cycles), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
